ifu_fetch: RTL and testbench

Instruction fetch unit for the NPC core: owns the program counter, issues one instruction-memory read per instruction over a valid/ready request channel, and captures the returned 32-bit word. It presents that word with its PC to the decode/control stage through a valid/ready handshake. The decode/control stage slices opcode, funct3 and funct7 from `inst`. Branch/jump resolution feeds back through a redirect port.

---
 rtl/npc_pkg.sv | 21 ++
 rtl/ifu_perf_cnt.sv | 33 +++
 rtl/ifu_fetch.sv | 164 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core front end: fetch FSM states,
// the canonical NOP encoding and the default reset PC.
package npc_pkg;

  // Fetch FSM: issue a request, wait for its data, hold it for decode.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0 -- shown to decode while nothing has been fetched yet.
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Sequential successor of a fetch address; wraps silently at 2^32.
  function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifu_perf_cnt.sv
// 32-bit saturating event counter with increment enable, cleared by rst.
module ifu_perf_cnt
  import npc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: add one on an event unless already pinned at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem read per
// instruction and hands the returned word plus its PC to decode.
// Redirects from branch resolution flush whatever is in flight.
// Optional feature macro IFU_PERF_EN: when defined, perf_fetched and
// perf_stall are live saturating counters; otherwise they read zero.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  fetch_state_e state_q, state_d;
  logic         drop_q, drop_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;
  logic         req_valid_q, req_valid_d;

  logic         req_fire;
  logic [31:0]  target_pc;
  logic         unused_redirect_lsb;

  // A request only counts once it is actually being presented; this keeps
  // the half-cycle after reset release (state REQ, valid still low) inert.
  assign req_fire  = req_valid_q & imem_req_ready;
  assign target_pc = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Next-state logic; a redirect outranks every other event in every state.
  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    unique case (state_q)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d = target_pc;
          // The old-PC request is already out; its data must be discarded.
          if (req_fire) begin
            state_d = ST_WAIT;
            drop_d  = 1'b1;
          end
        end else if (req_fire) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d = target_pc;
          if (imem_rsp_valid) begin
            // Stale data arrives right now: throw it away and refetch.
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            inst_d    = imem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          // A same-cycle inst_ready is still a consume, but the target wins.
          pc_d    = target_pc;
          state_d = ST_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_next_seq(pc_q);
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
        drop_d  = 1'b0;
      end
    endcase

    // Handshake outputs are registered from the state being entered.
    req_valid_d  = (state_d == ST_REQ);
    inst_valid_d = (state_d == ST_HOLD);
  end

  // FSM, PC and captured-instruction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_REQ;
      drop_q       <= 1'b0;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_pc_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
      req_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      req_valid_q  <= req_valid_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

`ifdef IFU_PERF_EN
  logic fetch_inc;
  logic stall_inc;

  assign fetch_inc = inst_valid_q & inst_ready;
  assign stall_inc = inst_valid_q & ~inst_ready;

  ifu_perf_cnt u_perf_fetched (
    .clk   (clk),
    .rst   (rst),
    .inc   (fetch_inc),
    .count (perf_fetched)
  );

  ifu_perf_cnt u_perf_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (perf_stall)
  );
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios followed by a random phase,
// all checked against a transaction-level model of the fetch stream.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IFU_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the architectural fetch PC and expected event counts.
  logic [31:0] m_pc;
  int          m_fetched;
  int          m_stall;
  // Memory agent: a single outstanding read with configurable latency.
  bit          rsp_pend;
  int          rsp_due;
  logic [31:0] rsp_addr;
  bit          outst;
  int          n_fires;
  int          n_cons;
  int          k_rdy, k_ir, k_rd, k_lat_min, k_lat_max;
  int          first;
  int          got;
  int          fires0;
  logic [31:0] f0, inst0, pc0, tgt;

  // Memory contents: a distinct word per aligned address, 0x93 at reset PC.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    logic [31:0] d;
    d = a - RST_PC;
    return {d[25:2], 8'h93} ^ {d[31:26], 26'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    chk({pfx, "_req_addr"}, imem_req_addr, RST_PC);
    chk({pfx, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({pfx, "_inst"}, inst, NOP);
    chk({pfx, "_inst_pc"}, inst_pc, RST_PC);
    chk({pfx, "_perf_fetched"}, perf_fetched, 32'd0);
    chk({pfx, "_perf_stall"}, perf_stall, 32'd0);
  endtask

  task automatic model_reset();
    m_pc      = RST_PC;
    m_fetched = 0;
    m_stall   = 0;
    outst     = 1'b0;
  endtask

  // Sample the current cycle's outputs mid-cycle and compare with the model.
  task automatic obs();
    @(negedge clk);
    chk("req_addr", imem_req_addr, m_pc);
    chk("one_outstanding", {31'd0, imem_req_valid & outst}, 32'd0);
    if (inst_valid) begin
      chk("inst_pc", inst_pc, m_pc);
      chk("inst", inst, memfn(m_pc));
    end
    chk("perf_fetched", perf_fetched, PERF ? m_fetched : 0);
    chk("perf_stall", perf_stall, PERF ? m_stall : 0);
  endtask

  // Drive this cycle's inputs (negative = random) and advance the model.
  task automatic drv(input int rdy, input int ir, input int rd, input logic [31:0] t);
    if (rsp_pend) rsp_due--;
    if (rsp_pend && rsp_due <= 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(rsp_addr);
      rsp_pend       = 1'b0;
      outst          = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (rsp_pend)     imem_req_ready = 1'b0;
    else if (rdy < 0) imem_req_ready = ($urandom_range(99, 0) < k_rdy);
    else              imem_req_ready = (rdy != 0);
    inst_ready     = (ir < 0) ? ($urandom_range(99, 0) < k_ir) : (ir != 0);
    redirect_valid = (rd < 0) ? ($urandom_range(99, 0) < k_rd) : (rd != 0);
    redirect_pc    = redirect_valid ? t : $urandom;

    if (imem_req_valid && imem_req_ready) begin
      rsp_pend = 1'b1;
      rsp_due  = $urandom_range(k_lat_max, k_lat_min);
      rsp_addr = imem_req_addr;
      outst    = 1'b1;
      n_fires++;
    end
    if (inst_valid) begin
      if (inst_ready) begin
        m_fetched++;
        n_cons++;
      end else begin
        m_stall++;
      end
    end
    if (redirect_valid)                m_pc = {redirect_pc[31:2], 2'b00};
    else if (inst_valid && inst_ready) m_pc = m_pc + 32'd4;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    rsp_pend = 1'b0; rsp_due = 0; rsp_addr = '0; n_fires = 0; n_cons = 0;
    k_rdy = 100; k_ir = 0; k_rd = 0; k_lat_min = 1; k_lat_max = 1;
    model_reset();

    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst_hold");
    rst = 1'b0;

    // Zero-wait memory: first instruction three edges after release.
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      obs();
      if (i == 1) begin
        chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, RST_PC);
      end
      if (inst_valid) begin
        first = i;
        break;
      end
      drv(1, 0, 0, 0);
    end
    chk("first_valid_latency", first, 3);
    chk("first_inst", inst, 32'h0000_0093);
    chk("first_inst_pc", inst_pc, RST_PC);

    // Decode stalls for five cycles, then consumes.
    inst0 = inst; pc0 = inst_pc;
    drv(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      obs();
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst", inst, inst0);
      chk("stall_inst_pc", inst_pc, pc0);
      drv(1, 0, 0, 0);
    end
    obs();
    drv(1, 1, 0, 0);
    obs();
    chk("second_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("second_req_addr", imem_req_addr, 32'h8000_0004);
    chk("stall_count", perf_stall, PERF ? 32'd5 : 32'd0);
    chk("fetch_count", perf_fetched, PERF ? 32'd1 : 32'd0);

    // Redirect while waiting on a two-cycle response.
    k_lat_min = 2; k_lat_max = 2;
    drv(1, 0, 0, 0);
    obs();
    drv(0, 0, 1, 32'h8000_0102);
    obs();
    chk("wait_redir_no_valid0", {31'd0, inst_valid}, 32'd0);
    drv(0, 0, 0, 0);
    obs();
    chk("wait_redir_no_valid1", {31'd0, inst_valid}, 32'd0);
    chk("wait_redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("wait_redir_req_addr", imem_req_addr, 32'h8000_0100);

    // Redirect coincident with a consume in HOLD.
    k_lat_min = 1; k_lat_max = 1;
    drv(1, 0, 0, 0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      obs();
      if (inst_valid) begin
        got = 1;
        break;
      end
      drv(1, 0, 0, 0);
    end
    chk("hold_reached", got, 1);
    f0 = perf_fetched;
    drv(1, 1, 1, 32'h8000_0040);
    obs();
    chk("hold_redir_req_addr", imem_req_addr, 32'h8000_0040);
    chk("hold_redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("hold_redir_fetched", perf_fetched, f0 + PERF);

    // Redirect coincident with a request handshake.
    drv(1, 0, 1, 32'h8000_0200);
    fires0 = n_fires;
    obs();
    chk("req_redir_no_valid", {31'd0, inst_valid}, 32'd0);
    drv(1, 0, 0, 0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      obs();
      if (inst_valid) begin
        got = 1;
        break;
      end
      drv(1, 0, 0, 0);
    end
    chk("req_redir_valid", {31'd0, inst_valid}, 32'd1);
    chk("req_redir_inst_pc", inst_pc, 32'h8000_0200);
    chk("req_redir_one_request", n_fires - fires0, 1);

    // Unaligned target near the top of memory, then wrap to zero.
    drv(1, 1, 1, 32'hFFFF_FFFE);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      obs();
      if (inst_valid) begin
        got = 1;
        break;
      end
      drv(1, 0, 0, 0);
    end
    chk("top_inst_pc", inst_pc, 32'hFFFF_FFFC);
    drv(1, 1, 0, 0);
    obs();
    chk("wrap_req_addr", imem_req_addr, 32'h0000_0000);
    chk("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);

    // Reset asserted in WAIT; the abandoned response then arrives in REQ.
    k_lat_min = 2; k_lat_max = 2;
    drv(1, 0, 0, 0);
    obs();
    drv(0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk_reset("rst_wait");
    model_reset();
    #2;
    rst = 1'b0;
    k_lat_min = 1; k_lat_max = 1;
    obs();
    chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_no_valid0", {31'd0, inst_valid}, 32'd0);
    drv(1, 0, 0, 0);
    obs();
    chk("post_rst_no_valid1", {31'd0, inst_valid}, 32'd0);
    drv(0, 0, 0, 0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      obs();
      if (inst_valid) begin
        got = 1;
        break;
      end
      drv(1, 0, 0, 0);
    end
    chk("post_rst_inst_pc", inst_pc, RST_PC);
    chk("post_rst_inst", inst, 32'h0000_0093);
    drv(1, 1, 0, 0);

    // Random phase: random ready, latency, decode backpressure, redirects.
    k_rdy = 60; k_ir = 60; k_rd = 8; k_lat_min = 1; k_lat_max = 3;
    n_cons = 0;
    for (int i = 0; i < 3000; i++) begin
      obs();
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0)) : $urandom;
      drv(-1, -1, -1, tgt);
    end
    chk("random_progress", {31'd0, n_cons >= 100}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
